// File: rtl/updown_cnt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : updown_cnt_ctrl
// Description : Triangle-sweep sequencer for the shared up/down counter.
//               Sweeps cnt_out between latched lower/upper limits, dwelling
//               at each endpoint, for (cfg_rep+1) periods. Provides a
//               start/busy/done handshake, abort and a direction flag.
//               Optional macro UPDOWN_CNT_CTRL_PAUSE_EN adds a pause input
//               that freezes the running sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_cnt_ctrl #(
  parameter int W  = 8,
  parameter int DW = 4,
  parameter int RW = 4
) (
  input  logic          sclk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
`ifdef UPDOWN_CNT_CTRL_PAUSE_EN
  input  logic          pause,
`endif
  input  logic [W-1:0]  cfg_lo,
  input  logic [W-1:0]  cfg_hi,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [RW-1:0] cfg_rep,
  output logic [W-1:0]  cnt_out,
  output logic          dir,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [2:0] c_ST_IDLE     = 3'd0;
  localparam logic [2:0] c_ST_UP       = 3'd1;
  localparam logic [2:0] c_ST_HOLD_TOP = 3'd2;
  localparam logic [2:0] c_ST_DOWN     = 3'd3;
  localparam logic [2:0] c_ST_HOLD_BOT = 3'd4;

  localparam logic [W-1:0]  c_ONE   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] c_DONE  = {DW{1'b0}};
  localparam logic [DW-1:0] c_D_ONE = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0] c_R_ONE = {{(RW-1){1'b0}}, 1'b1};

  logic [2:0]    r_state;
  logic [W-1:0]  r_lo;
  logic [W-1:0]  r_hi;
  logic [DW-1:0] r_dwell;
  logic [DW-1:0] r_dwell_cnt;
  logic [RW-1:0] r_rep_left;

  logic [W-1:0]  w_hi_m1;
  logic [W-1:0]  w_lo_p1;
  logic          w_freeze;

  // Neighbours of the endpoints; lo<hi at start guarantees no wrap.
  assign w_hi_m1 = r_hi - c_ONE;
  assign w_lo_p1 = r_lo + c_ONE;

`ifdef UPDOWN_CNT_CTRL_PAUSE_EN
  assign w_freeze = pause & busy;
`else
  assign w_freeze = 1'b0;
`endif

  // Sequencer: start acceptance, sweep/hold state machine, abort and pulses.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_ST_IDLE;
      r_lo        <= '0;
      r_hi        <= '0;
      r_dwell     <= '0;
      r_dwell_cnt <= '0;
      r_rep_left  <= '0;
      cnt_out     <= '0;
      dir         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (r_state == c_ST_IDLE) begin
        // abort is meaningless here, so start wins when both are high.
        if (start) begin
          if (cfg_lo < cfg_hi) begin
            r_lo       <= cfg_lo;
            r_hi       <= cfg_hi;
            r_dwell    <= cfg_dwell;
            r_rep_left <= cfg_rep;
            cnt_out    <= cfg_lo;
            dir        <= 1'b0;
            busy       <= 1'b1;
            r_state    <= c_ST_UP;
          end else begin
            err <= 1'b1;
          end
        end
      end else if (abort) begin
        // cnt_out and dir keep their last values after an abort.
        r_state <= c_ST_IDLE;
        busy    <= 1'b0;
      end else if (!w_freeze) begin
        case (r_state)
          c_ST_UP: begin
            if (cnt_out == w_hi_m1) begin
              cnt_out     <= r_hi;
              r_dwell_cnt <= r_dwell;
              r_state     <= c_ST_HOLD_TOP;
            end else begin
              cnt_out <= cnt_out + c_ONE;
            end
          end
          c_ST_HOLD_TOP: begin
            if (r_dwell_cnt != c_DONE) begin
              r_dwell_cnt <= r_dwell_cnt - c_D_ONE;
            end else begin
              dir     <= 1'b1;
              cnt_out <= w_hi_m1;
              // Span of one: the next value is already the bottom endpoint.
              if (w_hi_m1 == r_lo) begin
                r_dwell_cnt <= r_dwell;
                r_state     <= c_ST_HOLD_BOT;
              end else begin
                r_state <= c_ST_DOWN;
              end
            end
          end
          c_ST_DOWN: begin
            if (cnt_out == w_lo_p1) begin
              cnt_out     <= r_lo;
              r_dwell_cnt <= r_dwell;
              r_state     <= c_ST_HOLD_BOT;
            end else begin
              cnt_out <= cnt_out - c_ONE;
            end
          end
          c_ST_HOLD_BOT: begin
            if (r_dwell_cnt != c_DONE) begin
              r_dwell_cnt <= r_dwell_cnt - c_D_ONE;
            end else if (r_rep_left != '0) begin
              r_rep_left <= r_rep_left - c_R_ONE;
              dir        <= 1'b0;
              cnt_out    <= w_lo_p1;
              if (w_lo_p1 == r_hi) begin
                r_dwell_cnt <= r_dwell;
                r_state     <= c_ST_HOLD_TOP;
              end else begin
                r_state <= c_ST_UP;
              end
            end else begin
              // Final lo_q stays on cnt_out while idle.
              done    <= 1'b1;
              busy    <= 1'b0;
              dir     <= 1'b0;
              r_state <= c_ST_IDLE;
            end
          end
          default: begin
            r_state <= c_ST_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_updown_cnt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_cnt_ctrl
// Description : Self-checking bench for updown_cnt_ctrl. Expected per-cycle
//               cnt_out/dir values come from a triangle-waveform model built
//               from the limits, dwell and repeat count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_cnt_ctrl;

  logic       sclk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       pause;
  logic [7:0] cfg_lo;
  logic [7:0] cfg_hi;
  logic [3:0] cfg_dwell;
  logic [3:0] cfg_rep;
  logic [7:0] cnt_out;
  logic       dir;
  logic       busy;
  logic       done;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] q_cnt[$];
  logic       q_dir[$];

  updown_cnt_ctrl #(.W(8), .DW(4), .RW(4)) dut (
    .sclk     (sclk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
`ifdef UPDOWN_CNT_CTRL_PAUSE_EN
    .pause    (pause),
`endif
    .cfg_lo   (cfg_lo),
    .cfg_hi   (cfg_hi),
    .cfg_dwell(cfg_dwell),
    .cfg_rep  (cfg_rep),
    .cnt_out  (cnt_out),
    .dir      (dir),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 sclk = ~sclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Triangle waveform: one lo sample, then per period an up ramp, a top
  // plateau of d+1 samples, a down ramp and a bottom plateau of d+1 samples.
  function automatic void build_model(input int lo, input int hi, input int d, input int rep);
    q_cnt.delete();
    q_dir.delete();
    q_cnt.push_back(8'(lo)); q_dir.push_back(1'b0);
    for (int p = 0; p <= rep; p++) begin
      for (int v = lo + 1; v < hi; v++) begin q_cnt.push_back(8'(v)); q_dir.push_back(1'b0); end
      for (int k = 0; k <= d; k++)      begin q_cnt.push_back(8'(hi)); q_dir.push_back(1'b0); end
      for (int v = hi - 1; v > lo; v--) begin q_cnt.push_back(8'(v)); q_dir.push_back(1'b1); end
      for (int k = 0; k <= d; k++)      begin q_cnt.push_back(8'(lo)); q_dir.push_back(1'b1); end
    end
  endfunction

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic launch(input int lo, input int hi, input int d, input int rep);
    cfg_lo = 8'(lo); cfg_hi = 8'(hi); cfg_dwell = 4'(d); cfg_rep = 4'(rep);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0;
    cfg_lo = 8'd7; cfg_hi = 8'd9; cfg_dwell = 4'd1; cfg_rep = 4'd1;
    #3;
    n_cmp++;
    if ({cnt_out, dir, busy, done, err} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset: cnt=%0d dir=%b busy=%b done=%b err=%b, required all 0", cnt_out, dir, busy, done, err);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({cnt_out, dir, busy, done, err} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_release: cnt=%0d dir=%b busy=%b done=%b err=%b, required all 0", cnt_out, dir, busy, done, err);
    end
  endtask

  task automatic test_directed();
    int tl[3] = '{3, 10, 1};
    int th[3] = '{6, 11, 4};
    int td[3] = '{0, 2, 1};
    int tr[3] = '{0, 1, 2};
    for (int t = 0; t < 3; t++) begin
      build_model(tl[t], th[t], td[t], tr[t]);
      launch(tl[t], th[t], td[t], tr[t]);
      for (int i = 0; i < q_cnt.size(); i++) begin
        n_cmp++;
        if (cnt_out !== q_cnt[i] || dir !== q_dir[i] || busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
          n_bad++;
          $display("FAIL directed%0d[%0d]: cnt=%0d dir=%b busy=%b done=%b err=%b, required cnt=%0d dir=%b busy=1 done=0 err=0",
                   t, i, cnt_out, dir, busy, done, err, q_cnt[i], q_dir[i]);
        end
        step();
      end
      n_cmp++;
      if (cnt_out !== 8'(tl[t]) || dir !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
        n_bad++;
        $display("FAIL directed%0d_done: cnt=%0d dir=%b busy=%b done=%b, required cnt=%0d dir=0 busy=0 done=1",
                 t, cnt_out, dir, busy, done, tl[t]);
      end
      step();
      n_cmp++;
      if (cnt_out !== 8'(tl[t]) || busy !== 1'b0 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL directed%0d_idle: cnt=%0d busy=%b done=%b, required cnt=%0d busy=0 done=0",
                 t, cnt_out, busy, done, tl[t]);
      end
    end
  endtask

  task automatic test_err();
    logic [7:0] prev;
    int bl[2] = '{5, 9};
    int bh[2] = '{5, 4};
    for (int t = 0; t < 2; t++) begin
      prev = cnt_out;
      launch(bl[t], bh[t], 0, 0);
      n_cmp++;
      if (err !== 1'b1 || busy !== 1'b0 || cnt_out !== prev || done !== 1'b0) begin
        n_bad++;
        $display("FAIL err_pulse%0d: err=%b busy=%b cnt=%0d done=%b, required err=1 busy=0 cnt=%0d done=0",
                 t, err, busy, cnt_out, done, prev);
      end
      step();
      n_cmp++;
      if (err !== 1'b0 || busy !== 1'b0 || cnt_out !== prev) begin
        n_bad++;
        $display("FAIL err_clear%0d: err=%b busy=%b cnt=%0d, required err=0 busy=0 cnt=%0d", t, err, busy, cnt_out, prev);
      end
    end
    build_model(2, 5, 0, 0);
    launch(2, 5, 0, 0);
    for (int i = 0; i < q_cnt.size(); i++) begin
      n_cmp++;
      if (cnt_out !== q_cnt[i] || dir !== q_dir[i] || busy !== 1'b1 || err !== 1'b0) begin
        n_bad++;
        $display("FAIL err_follow[%0d]: cnt=%0d dir=%b busy=%b err=%b, required cnt=%0d dir=%b busy=1 err=0",
                 i, cnt_out, dir, busy, err, q_cnt[i], q_dir[i]);
      end
      step();
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || cnt_out !== 8'd2) begin
      n_bad++;
      $display("FAIL err_follow_done: done=%b busy=%b cnt=%0d, required done=1 busy=0 cnt=2", done, busy, cnt_out);
    end
    step();
  endtask

  task automatic test_abort();
    int  guard = 0;
    launch(0, 255, 0, 0);
    while (cnt_out !== 8'd100 && guard < 300) begin
      step();
      guard++;
    end
    n_cmp++;
    if (cnt_out !== 8'd100) begin
      n_bad++;
      $display("FAIL abort_reach: cnt=%0d after %0d cycles, required 100", cnt_out, guard);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (busy !== 1'b0 || cnt_out !== 8'd100 || done !== 1'b0 || dir !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_hold[%0d]: busy=%b cnt=%0d done=%b dir=%b, required busy=0 cnt=100 done=0 dir=0",
                 k, busy, cnt_out, done, dir);
      end
      step();
    end
    // Abort together with start in IDLE: start is honoured.
    abort = 1'b1;
    launch(20, 22, 0, 0);
    abort = 1'b0;
    build_model(20, 22, 0, 0);
    for (int i = 0; i < q_cnt.size(); i++) begin
      n_cmp++;
      if (cnt_out !== q_cnt[i] || dir !== q_dir[i] || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL abort_restart[%0d]: cnt=%0d dir=%b busy=%b, required cnt=%0d dir=%b busy=1",
                 i, cnt_out, dir, busy, q_cnt[i], q_dir[i]);
      end
      step();
    end
    n_cmp++;
    if (done !== 1'b1 || cnt_out !== 8'd20) begin
      n_bad++;
      $display("FAIL abort_restart_done: done=%b cnt=%0d, required done=1 cnt=20", done, cnt_out);
    end
    // Abort alone in IDLE does nothing.
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || cnt_out !== 8'd20 || done !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle: busy=%b cnt=%0d done=%b err=%b, required busy=0 cnt=20 done=0 err=0",
               busy, cnt_out, done, err);
    end
  endtask

  task automatic test_busy_ignore();
    build_model(4, 9, 1, 1);
    launch(4, 9, 1, 1);
    for (int i = 0; i < q_cnt.size(); i++) begin
      n_cmp++;
      if (cnt_out !== q_cnt[i] || dir !== q_dir[i] || busy !== 1'b1 || err !== 1'b0) begin
        n_bad++;
        $display("FAIL busy_ignore[%0d]: cnt=%0d dir=%b busy=%b err=%b, required cnt=%0d dir=%b busy=1 err=0",
                 i, cnt_out, dir, busy, err, q_cnt[i], q_dir[i]);
      end
      if (i == 3 || i == 11) begin
        start = 1'b1;
        cfg_lo = 8'($urandom_range(0, 100));
        cfg_hi = 8'($urandom_range(150, 255));
        cfg_dwell = 4'($urandom_range(0, 15));
        cfg_rep = 4'($urandom_range(0, 15));
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || cnt_out !== 8'd4) begin
      n_bad++;
      $display("FAIL busy_ignore_done: done=%b busy=%b cnt=%0d, required done=1 busy=0 cnt=4", done, busy, cnt_out);
    end
    step();
  endtask

  task automatic test_random();
    int lo, hi, d, rep;
    for (int t = 0; t < 15; t++) begin
      lo  = $urandom_range(0, 240);
      hi  = lo + $urandom_range(1, 12);
      d   = $urandom_range(0, 3);
      rep = $urandom_range(0, 2);
      build_model(lo, hi, d, rep);
      launch(lo, hi, d, rep);
      for (int i = 0; i < q_cnt.size(); i++) begin
        n_cmp++;
        if (cnt_out !== q_cnt[i] || dir !== q_dir[i] || busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
          n_bad++;
          $display("FAIL random%0d[%0d] lo=%0d hi=%0d d=%0d rep=%0d: cnt=%0d dir=%b busy=%b done=%b err=%b, required cnt=%0d dir=%b",
                   t, i, lo, hi, d, rep, cnt_out, dir, busy, done, err, q_cnt[i], q_dir[i]);
        end
        step();
      end
      n_cmp++;
      if (cnt_out !== 8'(lo) || dir !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
        n_bad++;
        $display("FAIL random%0d_done: cnt=%0d dir=%b busy=%b done=%b, required cnt=%0d dir=0 busy=0 done=1",
                 t, cnt_out, dir, busy, done, lo);
      end
      for (int g = 0; g < int'($urandom_range(1, 3)); g++) step();
    end
  endtask

  task automatic test_reset_mid();
    build_model(2, 8, 0, 0);
    launch(2, 8, 0, 0);
    for (int i = 0; i < 8; i++) step();
    n_cmp++;
    if (cnt_out !== q_cnt[8] || dir !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_pre: cnt=%0d dir=%b, required cnt=%0d dir=1", cnt_out, dir, q_cnt[8]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cnt_out, dir, busy, done, err} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_mid_async: cnt=%0d dir=%b busy=%b done=%b err=%b, required all 0", cnt_out, dir, busy, done, err);
    end
    step();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({cnt_out, dir, busy, done, err} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_mid_idle: cnt=%0d dir=%b busy=%b done=%b err=%b, required all 0", cnt_out, dir, busy, done, err);
    end
    launch(1, 3, 0, 0);
    n_cmp++;
    if (cnt_out !== 8'd1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_restart: cnt=%0d busy=%b, required cnt=1 busy=1", cnt_out, busy);
    end
    for (int i = 0; i < 6; i++) step();
  endtask

`ifdef UPDOWN_CNT_CTRL_PAUSE_EN
  task automatic test_pause();
    build_model(0, 20, 0, 0);
    pause = 1'b1;
    launch(0, 20, 0, 0);
    pause = 1'b0;
    for (int i = 0; i < q_cnt.size(); i++) begin
      n_cmp++;
      if (cnt_out !== q_cnt[i] || dir !== q_dir[i] || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL pause[%0d]: cnt=%0d dir=%b busy=%b, required cnt=%0d dir=%b busy=1",
                 i, cnt_out, dir, busy, q_cnt[i], q_dir[i]);
      end
      if (i == 5) begin
        pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
          step();
          n_cmp++;
          if (cnt_out !== q_cnt[5] || busy !== 1'b1 || dir !== 1'b0) begin
            n_bad++;
            $display("FAIL pause_frozen[%0d]: cnt=%0d busy=%b dir=%b, required cnt=%0d busy=1 dir=0",
                     k, cnt_out, busy, dir, q_cnt[5]);
          end
        end
        pause = 1'b0;
      end
      step();
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL pause_done: done=%b busy=%b, required done=1 busy=0", done, busy);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_err();
    test_abort();
    test_busy_ignore();
    test_random();
    test_reset_mid();
`ifdef UPDOWN_CNT_CTRL_PAUSE_EN
    test_pause();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
